// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage; owns the PC, issues instruction-memory
// requests over a req/valid handshake and loads the fetch/decode register.
// Ports: clk, rst_n (async active-low), enable, stall, flush, branch_pc,
//   imem_req/imem_addr/imem_rdata/imem_valid, curr_pc_fd, next_pc_fd,
//   curr_instr_fd, valid_fd, halted.
// Option: define FETCH_HALT_DETECT_EN to stop fetching after an HLT (opcode F).
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'hE000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] curr_pc_fd,
    output logic [15:0] next_pc_fd,
    output logic [15:0] curr_instr_fd,
    output logic        valid_fd,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state, n_state;
    logic [15:0] pc, n_pc;
    logic        req, n_req;
    logic        kill, n_kill;
    logic [15:0] redir, n_redir;
    logic [15:0] ibuf, n_ibuf;
    logic [15:0] fd_pc, n_fd_pc;
    logic [15:0] fd_npc, n_fd_npc;
    logic [15:0] fd_instr, n_fd_instr;
    logic        fd_valid, n_fd_valid;

    logic        adv;
    logic [15:0] pc_inc;
    logic        hlt_mem;
    logic        hlt_buf;

    assign adv    = enable & ~stall;
    assign pc_inc = pc + 16'd2;

`ifdef FETCH_HALT_DETECT_EN
    assign hlt_mem = (imem_rdata[15:12] == 4'hF);
    assign hlt_buf = (ibuf[15:12] == 4'hF);
    assign halted  = (state == S_HALT);
`else
    assign hlt_mem = 1'b0;
    assign hlt_buf = 1'b0;
    assign halted  = 1'b0;
`endif

    assign imem_req      = req;
    assign imem_addr     = pc;
    assign curr_pc_fd    = fd_pc;
    assign next_pc_fd    = fd_npc;
    assign curr_instr_fd = fd_instr;
    assign valid_fd      = fd_valid;

    always_comb begin
        n_state    = state;
        n_pc       = pc;
        n_req      = req;
        n_kill     = kill;
        n_redir    = redir;
        n_ibuf     = ibuf;
        n_fd_pc    = fd_pc;
        n_fd_npc   = fd_npc;
        n_fd_instr = fd_instr;
        n_fd_valid = fd_valid;

        unique case (state)
            S_FETCH: begin
                if (!req) begin
                    // Only after reset: raise the first request.
                    n_req = 1'b1;
                    if (flush) begin
                        n_pc       = branch_pc;
                        n_fd_instr = NOP_INSTR;
                        n_fd_valid = 1'b0;
                    end
                end else if (!imem_valid) begin
                    if (flush) begin
                        // Address must stay stable; redirect once the
                        // outstanding response is consumed.
                        n_redir    = branch_pc;
                        n_kill     = 1'b1;
                        n_fd_instr = NOP_INSTR;
                        n_fd_valid = 1'b0;
                    end else if (adv) begin
                        n_fd_instr = NOP_INSTR;
                        n_fd_valid = 1'b0;
                    end
                end else if (kill) begin
                    n_pc   = flush ? branch_pc : redir;
                    n_kill = 1'b0;
                    if (flush || adv) begin
                        n_fd_instr = NOP_INSTR;
                        n_fd_valid = 1'b0;
                    end
                end else if (flush) begin
                    n_pc       = branch_pc;
                    n_fd_instr = NOP_INSTR;
                    n_fd_valid = 1'b0;
                end else if (adv) begin
                    n_fd_pc    = pc;
                    n_fd_npc   = pc_inc;
                    n_fd_instr = imem_rdata;
                    n_fd_valid = 1'b1;
                    if (hlt_mem) begin
                        n_state = S_HALT;
                        n_req   = 1'b0;
                    end else begin
                        n_pc = pc_inc;
                    end
                end else begin
                    n_ibuf  = imem_rdata;
                    n_state = S_HOLD;
                    n_req   = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    n_pc       = branch_pc;
                    n_req      = 1'b1;
                    n_state    = S_FETCH;
                    n_fd_instr = NOP_INSTR;
                    n_fd_valid = 1'b0;
                end else if (adv) begin
                    n_fd_pc    = pc;
                    n_fd_npc   = pc_inc;
                    n_fd_instr = ibuf;
                    n_fd_valid = 1'b1;
                    if (hlt_buf) begin
                        n_state = S_HALT;
                    end else begin
                        n_pc    = pc_inc;
                        n_req   = 1'b1;
                        n_state = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                n_req = 1'b0;
                if (adv) begin
                    n_fd_instr = NOP_INSTR;
                    n_fd_valid = 1'b0;
                end
            end
            default: begin
                n_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            req      <= 1'b0;
            kill     <= 1'b0;
            redir    <= RESET_PC;
            ibuf     <= NOP_INSTR;
            fd_pc    <= 16'h0000;
            fd_npc   <= 16'h0000;
            fd_instr <= NOP_INSTR;
            fd_valid <= 1'b0;
        end else begin
            state    <= n_state;
            pc       <= n_pc;
            req      <= n_req;
            kill     <= n_kill;
            redir    <= n_redir;
            ibuf     <= n_ibuf;
            fd_pc    <= n_fd_pc;
            fd_npc   <= n_fd_npc;
            fd_instr <= n_fd_instr;
            fd_valid <= n_fd_valid;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven checks of fetch_stage.
// Each row drives one cycle of inputs and lists the outputs expected after it.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [15:0] branch_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] curr_pc_fd;
    logic [15:0] next_pc_fd;
    logic [15:0] curr_instr_fd;
    logic        valid_fd;
    logic        halted;

    int checks;
    int failures;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .stall        (stall),
        .flush        (flush),
        .branch_pc    (branch_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .curr_pc_fd   (curr_pc_fd),
        .next_pc_fd   (next_pc_fd),
        .curr_instr_fd(curr_instr_fd),
        .valid_fd     (valid_fd),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        st;
        logic        fl;
        logic [15:0] bpc;
        logic        v;
        logic [15:0] rd;
        logic        req;
        logic [15:0] addr;
        logic [15:0] cpc;
        logic [15:0] npc;
        logic [15:0] ins;
        logic        vfd;
        logic        hlt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(
        input logic en, input logic st, input logic fl,
        input logic [15:0] bpc, input logic v, input logic [15:0] rd,
        input logic req, input logic [15:0] addr, input logic [15:0] cpc,
        input logic [15:0] npc, input logic [15:0] ins, input logic vfd,
        input logic hlt);
        vec_t r;
        r.en = en; r.st = st; r.fl = fl; r.bpc = bpc; r.v = v; r.rd = rd;
        r.req = req; r.addr = addr; r.cpc = cpc; r.npc = npc;
        r.ins = ins; r.vfd = vfd; r.hlt = hlt;
        return r;
    endfunction

    task automatic check(input string name, input logic req,
        input logic [15:0] addr, input logic [15:0] cpc,
        input logic [15:0] npc, input logic [15:0] ins,
        input logic vfd, input logic hlt);
        logic [81:0] act;
        logic [81:0] exp;
        act = {imem_req, imem_addr, curr_pc_fd, next_pc_fd,
               curr_instr_fd, valid_fd, halted};
        exp = {req, addr, cpc, npc, ins, vfd, hlt};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got req=%b addr=%h pc=%h npc=%h ins=%h v=%b h=%b want req=%b addr=%h pc=%h npc=%h ins=%h v=%b h=%b",
                name, imem_req, imem_addr, curr_pc_fd, next_pc_fd,
                curr_instr_fd, valid_fd, halted,
                req, addr, cpc, npc, ins, vfd, hlt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n      = 1'b0;
        enable     = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        branch_pc  = 16'h0000;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;

        // zero-wait stream
        vecs[0]  = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0000,16'h0000,16'h0000,16'hE000,0,0);
        vecs[1]  = mk(1,0,0,16'h0000,1,16'h1000, 1,16'h0002,16'h0000,16'h0002,16'h1000,1,0);
        vecs[2]  = mk(1,0,0,16'h0000,1,16'h1002, 1,16'h0004,16'h0002,16'h0004,16'h1002,1,0);
        vecs[3]  = mk(1,0,0,16'h0000,1,16'h1004, 1,16'h0006,16'h0004,16'h0006,16'h1004,1,0);
        // slow memory: bubbles while waiting
        vecs[4]  = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0006,16'h0004,16'h0006,16'hE000,0,0);
        vecs[5]  = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0006,16'h0004,16'h0006,16'hE000,0,0);
        vecs[6]  = mk(1,0,0,16'h0000,1,16'h1006, 1,16'h0008,16'h0006,16'h0008,16'h1006,1,0);
        // stall across a response -> HOLD, then release
        vecs[7]  = mk(1,1,0,16'h0000,0,16'h0000, 1,16'h0008,16'h0006,16'h0008,16'h1006,1,0);
        vecs[8]  = mk(1,1,0,16'h0000,1,16'h1008, 0,16'h0008,16'h0006,16'h0008,16'h1006,1,0);
        vecs[9]  = mk(1,1,0,16'h0000,0,16'h0000, 0,16'h0008,16'h0006,16'h0008,16'h1006,1,0);
        vecs[10] = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h000A,16'h0008,16'h000A,16'h1008,1,0);
        // flush while a request is outstanding
        vecs[11] = mk(1,0,1,16'h0040,0,16'h0000, 1,16'h000A,16'h0008,16'h000A,16'hE000,0,0);
        vecs[12] = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h000A,16'h0008,16'h000A,16'hE000,0,0);
        vecs[13] = mk(1,0,0,16'h0000,1,16'h100A, 1,16'h0040,16'h0008,16'h000A,16'hE000,0,0);
        vecs[14] = mk(1,0,0,16'h0000,1,16'h1040, 1,16'h0042,16'h0040,16'h0042,16'h1040,1,0);
        // flush coinciding with a response; wrap at FFFE
        vecs[15] = mk(1,0,1,16'hFFFE,1,16'h1042, 1,16'hFFFE,16'h0040,16'h0042,16'hE000,0,0);
        vecs[16] = mk(1,0,0,16'h0000,1,16'h2222, 1,16'h0000,16'hFFFE,16'h0000,16'h2222,1,0);
        // flush out of HOLD, then a disabled cycle
        vecs[17] = mk(1,1,0,16'h0000,1,16'h3333, 0,16'h0000,16'hFFFE,16'h0000,16'h2222,1,0);
        vecs[18] = mk(1,1,1,16'h0008,0,16'h0000, 1,16'h0008,16'hFFFE,16'h0000,16'hE000,0,0);
        vecs[19] = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0008,16'hFFFE,16'h0000,16'hE000,0,0);
`ifdef FETCH_HALT_DETECT_EN
        vecs[20] = mk(1,0,0,16'h0000,1,16'hF000, 0,16'h0008,16'h0008,16'h000A,16'hF000,1,1);
        vecs[21] = mk(1,0,1,16'h0080,0,16'h0000, 0,16'h0008,16'h0008,16'h000A,16'hE000,0,1);
        vecs[22] = mk(1,0,0,16'h0000,1,16'h1234, 0,16'h0008,16'h0008,16'h000A,16'hE000,0,1);
`else
        vecs[20] = mk(1,0,0,16'h0000,1,16'hF000, 1,16'h000A,16'h0008,16'h000A,16'hF000,1,0);
        vecs[21] = mk(1,0,1,16'h0080,0,16'h0000, 1,16'h000A,16'h0008,16'h000A,16'hE000,0,0);
        vecs[22] = mk(1,0,0,16'h0000,1,16'h1234, 1,16'h0080,16'h0008,16'h000A,16'hE000,0,0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 0, 16'h0000, 16'h0000, 16'h0000, 16'hE000, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            enable     = vecs[i].en;
            stall      = vecs[i].st;
            flush      = vecs[i].fl;
            branch_pc  = vecs[i].bpc;
            imem_valid = vecs[i].v;
            imem_rdata = vecs[i].rd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                  vecs[i].cpc, vecs[i].npc, vecs[i].ins, vecs[i].vfd,
                  vecs[i].hlt);
            @(negedge clk);
        end

        // asynchronous reset mid-request; a stray response is ignored
        enable     = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("async_reset", 0, 16'h0000, 16'h0000, 16'h0000, 16'hE000, 0, 0);
        imem_valid = 1'b1;
        imem_rdata = 16'h5555;
        @(posedge clk);
        #1;
        check("reset_held", 0, 16'h0000, 16'h0000, 16'h0000, 16'hE000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_rise", 1, 16'h0000, 16'h0000, 16'h0000, 16'hE000, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("first_instr", 1, 16'h0002, 16'h0000, 16'h0002, 16'h5555, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
